// File: rtl/ps2_pkg.sv
// Shared constants and state encoding for the PS/2 receiver.
package ps2_pkg;
  localparam int PS2_FRAME_BITS         = 11;
  localparam int PS2_DEF_FILTER_LEN     = 8;
  localparam int PS2_DEF_TIMEOUT_CYCLES = 100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;
endpackage

// File: rtl/ps2_rx_if.sv
// Pin and result bundle of the PS/2 receiver; state is exported for observation.
interface ps2_rx_if;
  import ps2_pkg::*;

  logic       rx_en;
  logic       ps2d;
  logic       ps2c;
  logic [7:0] dout;
  // rx_done_tick is a one-cycle valid strobe with no ready: dout carries the
  // byte in that cycle and the consumer must take it then; there is no backpressure.
  logic       rx_done_tick;
  logic       frame_err;
  ps2_state_e state;

  modport master (output rx_en, ps2d, ps2c,
                  input  dout, rx_done_tick, frame_err, state);
  modport slave  (input  rx_en, ps2d, ps2c,
                  output dout, rx_done_tick, frame_err, state);
endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises ps2c/ps2d and debounces ps2c into a filtered level plus a falling-edge tick.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_s,
  output logic fall_tick
);
  logic [1:0]            c_sync_q, c_sync_d;
  logic [1:0]            d_sync_q, d_sync_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  level_q, level_d;

  always_comb begin
    c_sync_d = {c_sync_q[0], ps2c};
    d_sync_d = {d_sync_q[0], ps2d};
    filt_d   = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
    level_d  = level_q;
    // Level only moves on a unanimous window; mixed windows hold it.
    if (filt_q == '1)      level_d = 1'b1;
    else if (filt_q == '0) level_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      filt_q   <= '1;
      level_q  <= 1'b1;
    end else begin
      c_sync_q <= c_sync_d;
      d_sync_q <= d_sync_d;
      filt_q   <= filt_d;
      level_q  <= level_d;
    end
  end

  assign ps2d_s    = d_sync_q[1];
  assign fall_tick = level_q & (filt_q == '0);
endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB-first, odd parity, stop.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = PS2_DEF_TIMEOUT_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  ps2_rx_if.slave  bus
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic ps2d_s;
  logic fall_tick;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (bus.ps2c),
    .ps2d      (bus.ps2d),
    .ps2d_s    (ps2d_s),
    .fall_tick (fall_tick)
  );

  ps2_state_e                state_q, state_d;
  logic [PS2_FRAME_BITS-1:0] b_q, b_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [7:0]                dout_q, dout_d;
  logic                      frame_ok;
  logic                      done;
  logic                      err;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    dout_d  = dout_q;
    done    = 1'b0;
    err     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = b_q[PS2_FRAME_BITS-1] & ~b_q[0] & (^b_q[9:1]);
`else
    frame_ok = b_q[PS2_FRAME_BITS-1] & ~b_q[0];
`endif
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        // A high data line at a falling edge is a spurious edge, not a frame.
        if (fall_tick && bus.rx_en && !ps2d_s) begin
          b_d     = {ps2d_s, b_q[PS2_FRAME_BITS-1:1]};
          cnt_d   = 4'd9;
          state_d = RX;
        end
      end
      RX: begin
        if (fall_tick) begin
          b_d   = {ps2d_s, b_q[PS2_FRAME_BITS-1:1]};
          tmo_d = '0;
          if (cnt_q == 4'd0) state_d = CHECK;
          else               cnt_d   = cnt_q - 4'd1;
        end else if (tmo_q == TMO_LAST) begin
          err     = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok) begin
          done   = 1'b1;
          dout_d = b_q[8:1];
        end else begin
          err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
    end
  end

  // Bypass so the byte is already on dout during its done tick.
  assign bus.dout         = done ? b_q[8:1] : dout_q;
  assign bus.rx_done_tick = done;
  assign bus.frame_err    = err;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames plus randomized frames against a frame-level model.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FL  = 8;
  localparam int TMO = 400;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_rx_if bus();

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard state
  int         errors = 0;
  int         checks = 0;
  int         n_done = 0;
  int         n_err  = 0;
  bit         chk_en = 1'b0;
  logic [7:0] model_dout = 8'h00;
  int         exp_cyc_q[$];
  logic [8:0] exp_q[$];   // bit 8: 1 = good byte, 0 = frame error

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // per-cycle compare against the frame-level expectations
  always @(negedge clk) begin
    logic [8:0] ev;
    bit         exp_done;
    bit         exp_err;
    if (chk_en) begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        check("event_missed", cyc, exp_cyc_q[0]);
        void'(exp_cyc_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        void'(exp_cyc_q.pop_front());
        ev = exp_q.pop_front();
        if (ev[8]) begin
          exp_done   = 1'b1;
          model_dout = ev[7:0];
        end else begin
          exp_err = 1'b1;
        end
      end
      check("rx_done_tick", bus.rx_done_tick, exp_done);
      check("frame_err", bus.frame_err, exp_err);
      check("dout", bus.dout, model_dout);
      n_done += bus.rx_done_tick;
      n_err  += bus.frame_err;
      if (reset === 1'b0) begin
        model_dout = 8'h00;
        exp_cyc_q.delete();
        exp_q.delete();
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int at, input logic [8:0] ev);
    exp_cyc_q.push_back(at);
    exp_q.push_back(ev);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par_bad, input bit stop_val,
                            input int nbits, input int half);
    logic [10:0] fr;
    bit          acc;
    bit          good;
    int          k;
    fr   = {stop_val, (~^data) ^ par_bad, data, 1'b0};
    acc  = bus.rx_en;
    good = stop_val && !(PAR_EN && par_bad);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = fr[i];
      wait_cyc(half);
      bus.ps2c = 1'b0;
      k = cyc;
      if (i == nbits - 1 && acc) begin
        if (nbits == 11) push_exp(k + FL + 3, {good, data});
        else             push_exp(k + FL + 2 + TMO, 9'h000);
      end
      wait_cyc(half);
      bus.ps2c = 1'b1;
    end
    bus.ps2d = 1'b1;
  endtask

  initial begin
    int d0;
    int e0;
    int half;
    int nb;
    logic [7:0] rd;
    bus.rx_en = 1'b1;
    bus.ps2d  = 1'b1;
    bus.ps2c  = 1'b1;
    reset     = 1'b0;
    wait_cyc(5);
    reset  = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    check("reset_dout", bus.dout, 8'h00);
    check("reset_done", bus.rx_done_tick, 1'b0);
    check("reset_err", bus.frame_err, 1'b0);
    check("reset_state", bus.state, IDLE);
    wait_cyc(20);

    // 1: good 0x1C frame
    send_frame(8'h1C, 1'b0, 1'b1, 11, 20);
    wait_cyc(40);
    check("t1_dout", bus.dout, 8'h1C);
    check("t1_model", model_dout, 8'h1C);
    check("t1_ndone", n_done, 1);
    check("t1_nerr", n_err, 0);

    // 2: 0x1C with wrong parity
    d0 = n_done; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1, 11, 20);
    wait_cyc(40);
    check("t2_dout", bus.dout, 8'h1C);
    check("t2_ndone", n_done - d0, PAR_EN ? 0 : 1);
    check("t2_nerr", n_err - e0, PAR_EN ? 1 : 0);

    // 3: short glitch on ps2c
    d0 = n_done; e0 = n_err;
    bus.ps2c = 1'b0;
    wait_cyc(3);
    bus.ps2c = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_state", bus.state, IDLE);
    end
    wait_cyc(5);
    check("t3_ndone", n_done - d0, 0);
    check("t3_nerr", n_err - e0, 0);

    // 4: truncated frame then timeout, then 0x29
    d0 = n_done; e0 = n_err;
    send_frame(8'h29, 1'b0, 1'b1, 5, 20);
    wait_cyc(TMO + 60);
    check("t4_nerr", n_err - e0, 1);
    check("t4_state", bus.state, IDLE);
    check("t4_dout_kept", bus.dout, 8'h1C);
    send_frame(8'h29, 1'b0, 1'b1, 11, 20);
    wait_cyc(40);
    check("t4_dout", bus.dout, 8'h29);
    check("t4_ndone", n_done - d0, 1);

    // 5: reset mid-frame, then 0xF0
    send_frame(8'h55, 1'b0, 1'b1, 5, 20);
    reset = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_dout_rst", bus.dout, 8'h00);
    check("t5_state_rst", bus.state, IDLE);
    check("t5_done_rst", bus.rx_done_tick, 1'b0);
    check("t5_err_rst", bus.frame_err, 1'b0);
    wait_cyc(50);
    d0 = n_done; e0 = n_err;
    send_frame(8'hF0, 1'b0, 1'b1, 11, 20);
    wait_cyc(40);
    check("t5_dout", bus.dout, 8'hF0);
    check("t5_ndone", n_done - d0, 1);
    check("t5_nerr", n_err - e0, 0);

    // 6: frames ignored while rx_en is low
    d0 = n_done; e0 = n_err;
    bus.rx_en = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 20);
    wait_cyc(40);
    bus.rx_en = 1'b1;
    check("t6_ndone_off", n_done - d0, 0);
    check("t6_nerr_off", n_err - e0, 0);
    send_frame(8'h32, 1'b0, 1'b1, 11, 20);
    wait_cyc(40);
    check("t6_dout", bus.dout, 8'h32);

    // randomized frames
    for (int r = 0; r < 25; r++) begin
      half      = $urandom_range(12, 30);
      rd        = 8'($urandom_range(0, 255));
      nb        = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 10) : 11;
      bus.rx_en = ($urandom_range(0, 5) != 0);
      send_frame(rd, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0, nb, half);
      wait_cyc((nb < 11) ? TMO + 60 : $urandom_range(30, 120));
    end
    bus.rx_en = 1'b1;
    wait_cyc(20);
    check("final_queue_empty", exp_cyc_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
